// File: rtl/dsp_mac_pkg.sv
// Shared constants for the DSP48A1 MAC sequencer: OPMODE codes, FSM states, datapath widths.
package dsp_mac_pkg;
  localparam int A_W  = 18;
  localparam int P_W  = 48;
  localparam int OP_W = 8;

  // X mux in bits 1:0, Z mux in bits 3:2; upper nibble stays zero (no pre-add, no carry, add)
  localparam logic [OP_W-1:0] OP_HOLD_ZERO = 8'h00;
  localparam logic [OP_W-1:0] OP_FIRST     = 8'h01;
  localparam logic [OP_W-1:0] OP_HOLD      = 8'h08;
  localparam logic [OP_W-1:0] OP_ACC       = 8'h09;
  localparam logic [OP_W-1:0] OP_FIRST_C   = 8'h0D;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_e;
endpackage

// File: rtl/dsp_mac_pipe_tracker.sv
// Beat counter for the active command plus the drain counter that waits out the slice pipeline.
module dsp_mac_pipe_tracker #(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_beat,
  input  logic             i_drain,
  output logic             o_beats_left,
  output logic             o_last_beat,
  output logic             o_drain_done
);
  localparam int DW = $clog2(PIPE_LAT + 1);

  logic [LEN_W-1:0] r_remain;
  logic [DW-1:0]    r_drain_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_remain    <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (i_load)
        r_remain <= i_len;
      else if (i_beat && (r_remain != '0))
        r_remain <= r_remain - LEN_W'(1);
      if (!i_drain)
        r_drain_cnt <= '0;
      else if (!o_drain_done)
        r_drain_cnt <= r_drain_cnt + DW'(1);
    end
  end

  assign o_beats_left = (r_remain != '0);
  assign o_last_beat  = i_beat && (r_remain == LEN_W'(1));
  // First DRAIN cycle has the last operand on dsp_a/b; P is final PIPE_LAT cycles later.
  assign o_drain_done = i_drain && (r_drain_cnt == DW'(PIPE_LAT));
endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP48A1 slice as a MAC engine: command -> operand beats -> drain -> result P.
// Optional MAC_ROUND_EN: C carries the rounding constant and r_data = P >>> RND_SH.
module dsp_mac_sequencer
  import dsp_mac_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3,
  parameter int RND_SH   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  input  logic [LEN_W-1:0]      i_cmd_len,
  output logic                  o_cmd_ready,
  input  logic                  i_s_valid,
  input  logic signed [A_W-1:0] i_s_a,
  input  logic signed [A_W-1:0] i_s_b,
  output logic                  o_s_ready,
  output logic                  o_r_valid,
  output logic signed [P_W-1:0] o_r_data,
  input  logic                  i_r_ready,
  output logic signed [A_W-1:0] o_dsp_a,
  output logic signed [A_W-1:0] o_dsp_b,
  output logic [P_W-1:0]        o_dsp_c,
  output logic [OP_W-1:0]       o_dsp_opmode,
  input  logic signed [P_W-1:0] i_dsp_p
);
`ifdef MAC_ROUND_EN
  localparam logic [OP_W-1:0] OP_START = OP_FIRST_C;
  localparam logic [P_W-1:0]  C_CONST  = P_W'(1) << (RND_SH - 1);
`else
  localparam logic [OP_W-1:0] OP_START = OP_FIRST;
  localparam logic [P_W-1:0]  C_CONST  = '0;
`endif

  state_e                r_state, w_next;
  logic                  w_cmd_acc, w_beat, w_in_drain;
  logic                  w_beats_left, w_last_beat, w_drain_done;
  logic                  r_first;
  logic [OP_W-1:0]       w_op, r_op_pend, r_opmode;
  logic signed [A_W-1:0] r_a, r_b;
  logic [P_W-1:0]        r_c;
  logic                  r_rvalid;
  logic signed [P_W-1:0] r_rdata, w_res;

`ifdef MAC_ROUND_EN
  assign w_res = i_dsp_p >>> RND_SH;
`else
  assign w_res = i_dsp_p;
`endif

  assign o_cmd_ready = (r_state == IDLE);
  assign o_s_ready   = (r_state == ACC) && w_beats_left;
  assign w_cmd_acc   = i_cmd_valid && o_cmd_ready;
  assign w_beat      = i_s_valid && o_s_ready;
  assign w_in_drain  = (r_state == DRAIN);

  dsp_mac_pipe_tracker #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) u_trk (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_cmd_acc),
    .i_len        (i_cmd_len),
    .i_beat       (w_beat),
    .i_drain      (w_in_drain),
    .o_beats_left (w_beats_left),
    .o_last_beat  (w_last_beat),
    .o_drain_done (w_drain_done)
  );

  always_comb begin
    w_next = r_state;
    w_op   = OP_HOLD_ZERO;
    case (r_state)
      IDLE:    if (w_cmd_acc) w_next = (i_cmd_len == '0) ? DONE : ACC;
      ACC:     if (w_last_beat) w_next = DRAIN;
      DRAIN:   if (w_drain_done) w_next = DONE;
      DONE:    if (i_r_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // Bubbles and the drain keep P with X=0 so the repeated operand product is discarded.
    if (w_beat)
      w_op = r_first ? OP_START : OP_ACC;
    else if ((r_state == ACC) || (r_state == DRAIN))
      w_op = OP_HOLD;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_first   <= 1'b0;
      r_op_pend <= OP_HOLD_ZERO;
      r_opmode  <= OP_HOLD_ZERO;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_next;
      // Two-stage opmode path lines the code up with M at the slice post-adder.
      r_op_pend <= w_op;
      r_opmode  <= r_op_pend;
      r_c       <= C_CONST;
      if (w_cmd_acc)
        r_first <= 1'b1;
      else if (w_beat)
        r_first <= 1'b0;
      if (w_beat) begin
        r_a <= i_s_a;
        r_b <= i_s_b;
      end
      if (w_cmd_acc && (i_cmd_len == '0)) begin
        r_rvalid <= 1'b1;
        r_rdata  <= '0;
      end else if (w_drain_done) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_res;
      end else if ((r_state == DONE) && i_r_ready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign o_dsp_a      = r_a;
  assign o_dsp_b      = r_b;
  assign o_dsp_c      = r_c;
  assign o_dsp_opmode = r_opmode;
  assign o_r_valid    = r_rvalid;
  assign o_r_data     = r_rdata;
endmodule
